// File: rtl/input_mem_pingpong_ctrl.sv
// Ping-pong input-memory controller: DMA fills one bank while the
// other bank is read out row-skewed into the systolic array lanes.
module input_mem_pingpong_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2,
  localparam int CW = $clog2(DEPTH+1),
  localparam int AW = $clog2(DEPTH)+1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_start,
  input  logic [CW-1:0]                 wr_rows,
  output logic                          wr_ready,
  input  logic                          wr_valid,
  input  logic [SYS_ROW*DATA_WIDTH-1:0] wr_data,
  output logic                          wr_busy,
  output logic                          wr_done,
  output logic [SYS_ROW-1:0]            mem_wr_en,
  output logic [AW-1:0]                 mem_wr_addr,
  output logic [SYS_ROW*DATA_WIDTH-1:0] mem_wr_data,
  input  logic                          rd_start,
  output logic                          rd_ready,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic [SYS_ROW-1:0]            mem_rd_en,
  output logic [SYS_ROW*AW-1:0]         mem_rd_addr,
  output logic [SYS_ROW-1:0]            arr_vld
);

  localparam int RW = AW-1;
  // read phase counter must span N+SYS_ROW-1 issue cycles
  localparam int TW = $clog2(DEPTH+SYS_ROW+RD_LAT+1);
  localparam int DWT = SYS_ROW*DATA_WIDTH;

  typedef enum logic {W_IDLE, W_FILL} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rst_e;

  wst_e wst_q, wst_d;
  rst_e rst_q, rst_d;

  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][CW-1:0] rows_q, rows_d;

  logic [CW-1:0]     wr_n_q, wr_n_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     wr_clamp;
  logic [CW-1:0]     wr_cnt_nx;
  logic              wr_done_q, wr_done_d;
  logic [SYS_ROW-1:0] wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DWT-1:0]    wr_data_q, wr_data_d;
  logic              wr_set;

  logic [TW-1:0]     rd_n_q, rd_n_d;
  logic [TW-1:0]     rd_cyc_q, rd_cyc_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_clr;
  logic              rd_issue;

  logic [SYS_ROW-1:0] vld_q [RD_LAT];

  assign wr_clamp  = (wr_rows > CW'(DEPTH)) ? CW'(DEPTH) : wr_rows;
  assign wr_cnt_nx = wr_cnt_q + CW'(1);

  assign wr_busy     = (wst_q == W_FILL);
  assign wr_ready    = !wr_busy && !full_q[wr_ptr_q];
  assign wr_done     = wr_done_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;

  assign rd_busy  = (rst_q != R_IDLE) || rd_done_q;
  assign rd_ready = !rd_busy && full_q[rd_ptr_q];
  assign rd_done  = rd_done_q;
  assign rd_issue = (rst_q == R_ISSUE);
  assign arr_vld  = vld_q[RD_LAT-1];

  // write FSM: accept a fill, register each valid beat as an SRAM write
  always_comb begin
    wst_d     = wst_q;
    wr_ptr_d  = wr_ptr_q;
    wr_n_d    = wr_n_q;
    wr_cnt_d  = wr_cnt_q;
    wr_done_d = 1'b0;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_set    = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        if (wr_start && wr_ready) begin
          if (wr_clamp == '0) begin
            wr_done_d = 1'b1;
          end else begin
            wst_d    = W_FILL;
            wr_n_d   = wr_clamp;
            wr_cnt_d = '0;
          end
        end
      end
      W_FILL: begin
        if (wr_valid) begin
          wr_en_d   = '1;
          wr_addr_d = {wr_ptr_q, wr_cnt_q[RW-1:0]};
          wr_data_d = wr_data;
          wr_cnt_d  = wr_cnt_nx;
          if (wr_cnt_nx == wr_n_q) begin
            wr_done_d = 1'b1;
            wr_set    = 1'b1;
            wr_ptr_d  = ~wr_ptr_q;
            wst_d     = W_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // read FSM: skewed issue over N+SYS_ROW-1 cycles, then drain RD_LAT
  always_comb begin
    rst_d     = rst_q;
    rd_ptr_d  = rd_ptr_q;
    rd_n_d    = rd_n_q;
    rd_cyc_d  = rd_cyc_q;
    rd_done_d = 1'b0;
    rd_clr    = 1'b0;
    unique case (rst_q)
      R_IDLE: begin
        if (rd_done_q) begin
          rd_clr   = 1'b1;
          rd_ptr_d = ~rd_ptr_q;
        end
        if (rd_start && rd_ready) begin
          rst_d    = R_ISSUE;
          rd_n_d   = TW'(rows_q[rd_ptr_q]);
          rd_cyc_d = '0;
        end
      end
      R_ISSUE: begin
        if (rd_cyc_q == rd_n_q + TW'(SYS_ROW-2)) begin
          rst_d    = R_DRAIN;
          rd_cyc_d = '0;
        end else begin
          rd_cyc_d = rd_cyc_q + TW'(1);
        end
      end
      R_DRAIN: begin
        if (rd_cyc_q == TW'(RD_LAT-1)) begin
          rst_d     = R_IDLE;
          rd_done_d = 1'b1;
        end else begin
          rd_cyc_d = rd_cyc_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // bank occupancy: filled by the write side, freed by the read side
  always_comb begin
    full_d = full_q;
    rows_d = rows_q;
    if (wr_set) begin
      full_d[wr_ptr_q] = 1'b1;
      rows_d[wr_ptr_q] = wr_n_q;
    end
    if (rd_clr) begin
      full_d[rd_ptr_q] = 1'b0;
    end
  end

  // lane i lags lane 0 by i cycles; idle lanes drive address 0
  for (genvar i = 0; i < SYS_ROW; i++) begin : g_lane
    logic [TW-1:0] k;
    assign k = rd_cyc_q - TW'(i);
    assign mem_rd_en[i] = rd_issue && (rd_cyc_q >= TW'(i)) && (k < rd_n_q);
    assign mem_rd_addr[i*AW +: AW] =
      mem_rd_en[i] ? {rd_ptr_q, k[RW-1:0]} : '0;
  end

  // state registers for both sides and bank bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      full_q    <= '0;
      rows_q    <= '0;
      wr_n_q    <= '0;
      wr_cnt_q  <= '0;
      wr_done_q <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_n_q    <= '0;
      rd_cyc_q  <= '0;
      rd_done_q <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      rows_q    <= rows_d;
      wr_n_q    <= wr_n_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_done_q <= wr_done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_n_q    <= rd_n_d;
      rd_cyc_q  <= rd_cyc_d;
      rd_done_q <= rd_done_d;
    end
  end

  // array-valid is the read enable delayed by the SRAM latency
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < RD_LAT; j++) vld_q[j] <= '0;
    end else begin
      vld_q[0] <= mem_rd_en;
      for (int j = 1; j < RD_LAT; j++) vld_q[j] <= vld_q[j-1];
    end
  end

endmodule

// File: tb/tb_input_mem_pingpong_ctrl.sv
// Bench for the ping-pong input-memory controller: directed steps,
// expected writes/reads/done pulses queued and matched by monitors.
module tb_input_mem_pingpong_ctrl;

  localparam int SR    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int RL    = 2;
  localparam int CW    = 9;
  localparam int AW    = 9;

  typedef struct {
    int             cyc;
    logic [AW-1:0]  addr;
    logic [SR*DW-1:0] data;
  } wexp_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } rexp_t;

  logic              clk;
  logic              rstn;
  logic              wr_start;
  logic [CW-1:0]     wr_rows;
  logic              wr_ready;
  logic              wr_valid;
  logic [SR*DW-1:0]  wr_data;
  logic              wr_busy;
  logic              wr_done;
  logic [SR-1:0]     mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [SR*DW-1:0]  mem_wr_data;
  logic              rd_start;
  logic              rd_ready;
  logic              rd_busy;
  logic              rd_done;
  logic [SR-1:0]     mem_rd_en;
  logic [SR*AW-1:0]  mem_rd_addr;
  logic [SR-1:0]     arr_vld;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_on = 0;

  wexp_t wq[$];
  rexp_t rq[2][$];
  int    vq15[$];
  int    wdq[$];
  int    rdq[$];

  input_mem_pingpong_ctrl #(
    .SYS_ROW(SR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_start(wr_start), .wr_rows(wr_rows), .wr_ready(wr_ready),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_busy(wr_busy),
    .wr_done(wr_done), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_busy(rd_busy),
    .rd_done(rd_done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .arr_vld(arr_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitors: every observed event must match the head of its queue
  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_wr_en != '0) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", mem_wr_en, 0);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wr_en", mem_wr_en, {SR{1'b1}});
          chk("wr_cyc", cyc, e.cyc);
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_data", mem_wr_data, e.data);
        end
      end
      for (int l = 0; l < 2; l++) begin
        int ln;
        ln = l * (SR-1);
        if (mem_rd_en[ln]) begin
          if (rq[l].size() == 0) begin
            chk("rd_unexpected", mem_rd_en[ln], 0);
          end else begin
            rexp_t r;
            r = rq[l].pop_front();
            chk("rd_cyc", cyc, r.cyc);
            chk("rd_addr", mem_rd_addr[ln*AW +: AW], r.addr);
          end
        end else begin
          chk("rd_addr_idle", mem_rd_addr[ln*AW +: AW], 0);
        end
      end
      if (arr_vld[SR-1]) begin
        if (vq15.size() == 0) chk("vld_unexpected", arr_vld[SR-1], 0);
        else chk("vld15_cyc", cyc, vq15.pop_front());
      end
      if (wr_done) begin
        if (wdq.size() == 0) chk("wr_done_unexpected", wr_done, 0);
        else chk("wr_done_cyc", cyc, wdq.pop_front());
      end
      if (rd_done) begin
        chk("rd_busy_at_done", rd_busy, 1);
        if (rdq.size() == 0) chk("rd_done_unexpected", rd_done, 0);
        else chk("rd_done_cyc", cyc, rdq.pop_front());
      end
    end
  end

  task automatic do_fill(input int n, input int bank, input bit gappy,
                         input int abort_at);
    int nn;
    int k;
    int ph;
    logic [SR*DW-1:0] wd;
    nn = (n > DEPTH) ? DEPTH : n;
    chk("wr_ready_pre", wr_ready, 1);
    wr_start = 1'b1;
    wr_rows  = CW'(n);
    if (nn == 0) wdq.push_back(cyc + 1);
    tick();
    wr_start = 1'b0;
    k  = 0;
    ph = 0;
    while (k < nn && (abort_at < 0 || k < abort_at)) begin
      for (int j = 0; j < SR*DW/32; j++) wd[j*32 +: 32] = $urandom();
      wr_data = wd;
      if (!gappy || (ph % 2) == 0) begin
        wr_valid = 1'b1;
        wq.push_back('{cyc: cyc + 1, addr: AW'(bank*DEPTH + k), data: wd});
        k++;
        if (k == nn) wdq.push_back(cyc + 1);
      end else begin
        wr_valid = 1'b0;
      end
      ph++;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int n, input int bank);
    int t;
    chk("rd_ready_pre", rd_ready, 1);
    rd_start = 1'b1;
    t = cyc;
    for (int k = 0; k < n; k++) begin
      rq[0].push_back('{cyc: t + 1 + k, addr: AW'(bank*DEPTH + k)});
      rq[1].push_back('{cyc: t + SR + k, addr: AW'(bank*DEPTH + k)});
      vq15.push_back(t + SR + RL + k);
    end
    rdq.push_back(t + n + SR + RL);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_rd(input int limit);
    int n;
    n = 0;
    while (rd_busy && n < limit) begin
      tick();
      n++;
    end
    chk("rd_timeout", rd_busy, 0);
  endtask

  task automatic chk_idle_outputs();
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_arr_vld", arr_vld, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
  endtask

  initial begin
    rstn = 1'b0;
    wr_start = 1'b0;
    wr_rows = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_start = 1'b0;
    tick();
    tick();
    chk_idle_outputs();
    mon_on = 1'b1;
    rstn = 1'b1;
    tick();

    // step 1: fill 4 rows into bank0
    do_fill(4, 0, 1'b0, -1);
    tick();
    chk("s1_rd_ready", rd_ready, 1);
    chk("s1_wr_ready", wr_ready, 1);
    chk("s1_wr_busy", wr_busy, 0);

    // steps 2-3: read bank0 while filling bank1
    do_read(4, 0);
    do_fill(5, 1, 1'b0, -1);
    tick();
    chk("s3_wr_ready_both_full", wr_ready, 0);
    chk("s3_rd_ready_busy", rd_ready, 0);
    wait_rd(60);
    chk("s3_wr_ready_freed", wr_ready, 1);
    chk("s3_rd_ready_bank1", rd_ready, 1);
    do_read(5, 1);
    wait_rd(60);
    chk("s3_rd_ready_empty", rd_ready, 0);

    // step 4: gappy valid, 3 rows into bank0, then read it back
    do_fill(3, 0, 1'b1, -1);
    tick();
    do_read(3, 0);
    wait_rd(60);

    // step 5: zero-row fill, stray beats while idle, clamped fill
    do_fill(0, 1, 1'b0, -1);
    wr_valid = 1'b1;
    tick();
    tick();
    wr_valid = 1'b0;
    chk("s5_rd_ready_zero", rd_ready, 0);
    chk("s5_wr_ready_zero", wr_ready, 1);
    do_fill(300, 1, 1'b0, -1);
    tick();
    chk("s5_rd_ready_clamp", rd_ready, 1);
    do_read(DEPTH, 1);
    wait_rd(400);

    // step 6: reset while reading bank0 and filling bank1
    do_fill(8, 0, 1'b0, -1);
    tick();
    do_read(8, 0);
    do_fill(8, 1, 1'b0, 3);
    rstn = 1'b0;
    tick();
    wq.delete();
    rq[0].delete();
    rq[1].delete();
    vq15.delete();
    wdq.delete();
    rdq.delete();
    chk_idle_outputs();
    rstn = 1'b1;
    repeat (30) tick();
    chk("s6_wr_ready", wr_ready, 1);
    chk("s6_rd_ready", rd_ready, 0);
    do_fill(2, 0, 1'b0, -1);
    tick();
    chk("s6_rd_ready_refill", rd_ready, 1);
    repeat (3) tick();

    chk("q_wr_empty", wq.size(), 0);
    chk("q_rd0_empty", rq[0].size(), 0);
    chk("q_rd15_empty", rq[1].size(), 0);
    chk("q_vld_empty", vq15.size(), 0);
    chk("q_wdone_empty", wdq.size(), 0);
    chk("q_rdone_empty", rdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
